apb_master: RTL

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_timeout_counter.sv | 32 +++
 rtl/apb_master.sv | 139 +++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB master types: transfer state encoding, default widths and timeout.
// The counter width helper is sized so a count of TIMEOUT never wraps.
package apb_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_TIMEOUT    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// ACCESS wait-state counter: cleared on transfer start, counts PREADY-low cycles.
// Saturates at TIMEOUT-1 and flags expiry; no latency beyond the count register.
module apb_timeout_counter
  import apb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int            CW    = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: cmd handshake -> SETUP -> ACCESS -> one-cycle rsp pulse.
// Min 3 cycles handshake-to-rsp; cmd_ready only in IDLE, ACCESS aborts after TIMEOUT waits.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int SW = DATA_WIDTH / 8;

  apb_state_e r_state;
  apb_state_e w_next;
  logic       w_hs;
  logic       w_done;
  logic       w_abort;
  logic       w_expired;

  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [SW-1:0]         r_pstrb;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;
  logic                  r_rsp_timeout;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_hs    = 1'b0;
    w_done  = 1'b0;
    w_abort = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_hs   = 1'b1;
          w_next = SETUP;
        end
      end
      SETUP: w_next = ACCESS;
      ACCESS: begin
        // A ready slave wins over expiry on the last permitted cycle.
        if (PREADY) begin
          w_done = 1'b1;
          w_next = IDLE;
        end else if (w_expired) begin
          w_abort = 1'b1;
          w_next  = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_rsp_valid <= w_done | w_abort;
      if (w_hs) begin
        r_pwrite <= cmd_write;
        r_paddr  <= cmd_addr;
        r_pwdata <= cmd_wdata;
        r_pstrb  <= cmd_write ? cmd_strb : '0;
      end
      if (w_done) begin
        r_rsp_rdata   <= r_pwrite ? '0 : PRDATA;
        r_rsp_err     <= PSLVERR;
        r_rsp_timeout <= 1'b0;
      end else if (w_abort) begin
        r_rsp_rdata   <= '0;
        r_rsp_err     <= 1'b1;
        r_rsp_timeout <= 1'b1;
      end
    end
  end

  apb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk     (PCLK),
    .i_rst     (PRESET),
    .i_clear   (w_hs),
    .i_enable  ((r_state == ACCESS) && !PREADY),
    .o_expired (w_expired)
  );

  // Bus strobes decode straight from state so an async reset drops them at once.
  assign PSEL        = (r_state != IDLE);
  assign PENABLE     = (r_state == ACCESS);
  assign cmd_ready   = (r_state == IDLE) && !PRESET;
  assign PWRITE      = r_pwrite;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign PSTRB       = r_pstrb;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

endmodule
